// File: rtl/pipe_tx_scrambler.sv
// ---------------------------------------------------------------------------
// pipe_tx_scrambler
//
// Per-lane transmit scrambler sitting directly upstream of the PIPE TX data
// mapper. Gen1/2 beats use the 16-bit 8b/10b-domain scrambler. Gen3+ beats
// use the 23-bit 128b/130b scrambler with block framing and ordered-set
// handling. There is one registered stage between input beat and output beat.
//
// Optional build macro: PIPE_SCRAMBLE_BYPASS_EN adds the scrambleDisable
// input. When it is high, data passes unscrambled while the LFSRs still step
// exactly as in normal operation.
//
// Ports:
//   pclk                 clock
//   reset                asynchronous reset, active-high
//   generation[2:0]      1..5 selects the PCIe generation; other values = idle
//   linkData[31:0]       input symbols, byte 0 in [7:0] goes first
//   linkDataK[3:0]       per-byte K flag (Gen1/2)
//   linkSyncHeader[1:0]  Gen3+ sync header, used on block-start beats
//   linkStartBlock       first beat of a 128b/130b block
//   linkDataValid        beat qualifier
//   scrambleDisable      (PIPE_SCRAMBLE_BYPASS_EN only) pass data unscrambled
//   scramblerDataOut     scrambled symbols, unused upper bytes are 0
//   scramblerDataK       K flags, Gen1/2 only, unused bytes 0
//   scramblerSyncHeader  sync header on block-start beats, else 0
//   scramblerDataValid   delayed linkDataValid
//
// Handshake: there is no backpressure. A beat is accepted on every pclk edge
// where linkDataValid=1 and generation is 1..5; its result is presented on the
// outputs for exactly the following cycle with scramblerDataValid=1.
// ---------------------------------------------------------------------------
module pipe_tx_scrambler #(
  parameter int unsigned pipe_width_gen1 = 8,
  parameter int unsigned pipe_width_gen2 = 8,
  parameter int unsigned pipe_width_gen3 = 16,
  parameter int unsigned pipe_width_gen4 = 32,
  parameter int unsigned pipe_width_gen5 = 32,
  parameter logic [22:0] LANE_SEED       = 23'h1DBFBC
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [2:0]  generation,
  input  logic [31:0] linkData,
  input  logic [3:0]  linkDataK,
  input  logic [1:0]  linkSyncHeader,
  input  logic        linkStartBlock,
  input  logic        linkDataValid,
`ifdef PIPE_SCRAMBLE_BYPASS_EN
  input  logic        scrambleDisable,
`endif
  output logic [31:0] scramblerDataOut,
  output logic [3:0]  scramblerDataK,
  output logic [1:0]  scramblerSyncHeader,
  output logic        scramblerDataValid
);

  localparam logic [15:0] LFSR12_INIT = 16'hFFFF;
  localparam logic [7:0]  SYM_COM     = 8'hBC;
  localparam logic [7:0]  SYM_SKP     = 8'h1C;

  typedef enum logic [1:0] {
    BT_DATA     = 2'd0,
    BT_OTHER_OS = 2'd1,
    BT_SKP      = 2'd2,
    BT_EIEOS    = 2'd3
  } blk_type_e;

  // Gen1/2: x^16+x^5+x^4+x^3+1, Galois, output taken from bit 15.
  function automatic logic [15:0] adv16(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ (r[15] ? 16'h0039 : 16'h0000);
    return r;
  endfunction

  function automatic logic [7:0] ks16(input logic [15:0] s);
    logic [15:0] r;
    logic [7:0]  k;
    r = s;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[i] = r[15];
      r = {r[14:0], 1'b0} ^ (r[15] ? 16'h0039 : 16'h0000);
    end
    return k;
  endfunction

  // Gen3+: x^23+x^21+x^16+x^8+x^5+x^2+1, Galois, output taken from bit 22.
  function automatic logic [22:0] adv23(input logic [22:0] s);
    logic [22:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = {r[21:0], 1'b0} ^ (r[22] ? 23'h210125 : 23'h0);
    return r;
  endfunction

  function automatic logic [7:0] ks23(input logic [22:0] s);
    logic [22:0] r;
    logic [7:0]  k;
    r = s;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[i] = r[22];
      r = {r[21:0], 1'b0} ^ (r[22] ? 23'h210125 : 23'h0);
    end
    return k;
  endfunction

  logic [15:0] lfsr12_q, lfsr12_d;
  logic [22:0] lfsr3_q,  lfsr3_d;
  logic [3:0]  cnt_q,    cnt_d;
  blk_type_e   btype_q,  btype_d;
  logic [2:0]  gen_q;
  logic [31:0] data_q,   data_d;
  logic [3:0]  k_q,      k_d;
  logic [1:0]  sh_q,     sh_d;
  logic        valid_q,  valid_d;

  logic scr_off;
`ifdef PIPE_SCRAMBLE_BYPASS_EN
  assign scr_off = scrambleDisable;
`else
  assign scr_off = 1'b0;
`endif

  logic        gen_ok, gen_q_ok, gen_chg, is_gen3;
  int          nbytes;
  logic [15:0] l12;
  logic [22:0] l3;
  logic [3:0]  idx;
  blk_type_e   bt;
  logic        frame_err;
  logic [7:0]  byte_in;

  assign gen_ok   = (generation >= 3'd1) && (generation <= 3'd5);
  assign gen_q_ok = (gen_q >= 3'd1) && (gen_q <= 3'd5);
  // A change away from an active generation must reinitialise. Coming out of
  // idle (or reset) the state already sits at its reset values.
  assign gen_chg  = gen_q_ok && (generation != gen_q);
  assign is_gen3  = (generation >= 3'd3);

  always_comb begin
    case (generation)
      3'd1:    nbytes = int'(pipe_width_gen1 / 8);
      3'd2:    nbytes = int'(pipe_width_gen2 / 8);
      3'd3:    nbytes = int'(pipe_width_gen3 / 8);
      3'd4:    nbytes = int'(pipe_width_gen4 / 8);
      3'd5:    nbytes = int'(pipe_width_gen5 / 8);
      default: nbytes = 0;
    endcase
  end

  always_comb begin
    lfsr12_d  = lfsr12_q;
    lfsr3_d   = lfsr3_q;
    cnt_d     = cnt_q;
    btype_d   = btype_q;
    data_d    = '0;
    k_d       = '0;
    sh_d      = '0;
    valid_d   = 1'b0;
    l12       = lfsr12_q;
    l3        = lfsr3_q;
    idx       = cnt_q;
    bt        = btype_q;
    frame_err = 1'b0;
    byte_in   = '0;

    if (gen_ok && linkDataValid) begin
      valid_d = 1'b1;
      if (!is_gen3) begin
        for (int b = 0; b < 4; b++) begin
          if (b < nbytes) begin
            byte_in = linkData[8*b +: 8];
            k_d[b]  = linkDataK[b];
            if (linkDataK[b]) begin
              // Control symbols are never scrambled; COM resyncs, SKP freezes.
              data_d[8*b +: 8] = byte_in;
              if (byte_in == SYM_COM)      l12 = LFSR12_INIT;
              else if (byte_in != SYM_SKP) l12 = adv16(l12);
            end else begin
              data_d[8*b +: 8] = byte_in ^ (scr_off ? 8'h00 : ks16(l12));
              l12 = adv16(l12);
            end
          end
        end
        lfsr12_d = l12;
      end else begin
        if (linkStartBlock) begin
          idx  = 4'd0;
          sh_d = linkSyncHeader;
          if (linkSyncHeader == 2'b01) begin
            if (linkData[7:0] == 8'hAA)      bt = BT_SKP;
            else if (linkData[7:0] == 8'h00) bt = BT_EIEOS;
            else                             bt = BT_OTHER_OS;
          end else begin
            bt = BT_DATA;
          end
        end else if (cnt_q == 4'd0) begin
          // Mid-block beat with no block open: pass through and keep waiting
          // for a real block start.
          frame_err = 1'b1;
        end

        for (int b = 0; b < 4; b++) begin
          if (b < nbytes) begin
            byte_in = linkData[8*b +: 8];
            if (frame_err) begin
              data_d[8*b +: 8] = byte_in;
            end else begin
              case (bt)
                BT_DATA: begin
                  data_d[8*b +: 8] = byte_in ^ (scr_off ? 8'h00 : ks23(l3));
                  l3 = adv23(l3);
                end
                BT_OTHER_OS: begin
                  // Ordered-set identifier byte is sent in the clear but still
                  // consumes keystream.
                  data_d[8*b +: 8] = (idx == 4'd0 || scr_off) ? byte_in : (byte_in ^ ks23(l3));
                  l3 = adv23(l3);
                end
                BT_SKP: begin
                  data_d[8*b +: 8] = byte_in;
                end
                BT_EIEOS: begin
                  data_d[8*b +: 8] = byte_in;
                  if (idx == 4'd15) l3 = LANE_SEED;
                end
                default: data_d[8*b +: 8] = byte_in;
              endcase
              idx = idx + 4'd1;
            end
          end
        end

        if (!frame_err) begin
          lfsr3_d = l3;
          cnt_d   = idx;
          btype_d = bt;
        end
      end
    end

    if (!gen_ok || gen_chg) begin
      lfsr12_d = LFSR12_INIT;
      lfsr3_d  = LANE_SEED;
      cnt_d    = 4'd0;
      btype_d  = BT_DATA;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      lfsr12_q <= LFSR12_INIT;
      lfsr3_q  <= LANE_SEED;
      cnt_q    <= 4'd0;
      btype_q  <= BT_DATA;
      gen_q    <= 3'd0;
      data_q   <= '0;
      k_q      <= '0;
      sh_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      lfsr12_q <= lfsr12_d;
      lfsr3_q  <= lfsr3_d;
      cnt_q    <= cnt_d;
      btype_q  <= btype_d;
      gen_q    <= generation;
      data_q   <= data_d;
      k_q      <= k_d;
      sh_q     <= sh_d;
      valid_q  <= valid_d;
    end
  end

  assign scramblerDataOut    = data_q;
  assign scramblerDataK      = k_q;
  assign scramblerSyncHeader = sh_q;
  assign scramblerDataValid  = valid_q;

endmodule

// File: tb/tb_pipe_tx_scrambler.sv
module tb_pipe_tx_scrambler;

  localparam logic [22:0] SEED = 23'h1DBFBC;

  typedef struct packed {
    logic        v;
    logic        st;
    logic        dis;
    logic [1:0]  sh;
    logic [3:0]  k;
    logic [31:0] d;
    logic [38:0] e;   // {valid, sync header, K, data}
  } beat_t;

  typedef logic [7:0] blk_t [16];

  logic        pclk;
  logic        reset;
  logic [2:0]  gen;
  logic [31:0] link_data;
  logic [3:0]  link_k;
  logic [1:0]  link_sh;
  logic        link_st;
  logic        link_v;
  logic [31:0] out_data;
  logic [3:0]  out_k;
  logic [1:0]  out_sh;
  logic        out_v;
`ifdef PIPE_SCRAMBLE_BYPASS_EN
  logic        scr_dis;
`endif

  beat_t       plan_q[$];
  logic [38:0] exp_q[$];
  logic [15:0] m16;
  logic [22:0] m23;
  int          n_vec;
  int          n_mis;

  pipe_tx_scrambler dut (
    .pclk                (pclk),
    .reset               (reset),
    .generation          (gen),
    .linkData            (link_data),
    .linkDataK           (link_k),
    .linkSyncHeader      (link_sh),
    .linkStartBlock      (link_st),
    .linkDataValid       (link_v),
`ifdef PIPE_SCRAMBLE_BYPASS_EN
    .scrambleDisable     (scr_dis),
`endif
    .scramblerDataOut    (out_data),
    .scramblerDataK      (out_k),
    .scramblerSyncHeader (out_sh),
    .scramblerDataValid  (out_v)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  // ---------------- reference keystream models ----------------
  function automatic logic [7:0] ks16_next();
    logic [7:0] k;
    logic       fb;
    k = '0;
    for (int j = 0; j < 8; j++) begin
      fb     = m16[15];
      k[j]   = fb;
      m16    = {m16[14:0], fb};
      m16[3] = m16[3] ^ fb;
      m16[4] = m16[4] ^ fb;
      m16[5] = m16[5] ^ fb;
    end
    return k;
  endfunction

  function automatic logic [7:0] ks23_next();
    logic [7:0] k;
    logic       fb;
    k = '0;
    for (int j = 0; j < 8; j++) begin
      fb      = m23[22];
      k[j]    = fb;
      m23     = {m23[21:0], fb};
      m23[2]  = m23[2]  ^ fb;
      m23[5]  = m23[5]  ^ fb;
      m23[8]  = m23[8]  ^ fb;
      m23[16] = m23[16] ^ fb;
      m23[21] = m23[21] ^ fb;
    end
    return k;
  endfunction

  // ---------------- stimulus planning ----------------
  task automatic plan_idle();
    beat_t b;
    b = '0;
    plan_q.push_back(b);
  endtask

  // Gen1/2 single-byte beat with an explicitly given expected byte.
  task automatic plan_fix(input logic [7:0] d, input logic k, input logic [7:0] e);
    beat_t b;
    b      = '0;
    b.v    = 1'b1;
    b.d    = {24'h0, d};
    b.k    = {3'b0, k};
    b.e    = {1'b1, 2'b00, 3'b0, k, 24'h0, e};
    plan_q.push_back(b);
  endtask

  // Gen1/2 single-byte beat, expected from the 16-bit model.
  task automatic plan_g12(input logic [7:0] d, input logic k, input logic v);
    beat_t b;
    b   = '0;
    b.v = v;
    b.d = {24'h0, d};
    b.k = {3'b0, k};
    if (v) begin
      b.e[38]    = 1'b1;
      b.e[35:32] = {3'b0, k};
      if (k) begin
        b.e[7:0] = d;
        if (d == 8'hBC)      m16 = 16'hFFFF;
        else if (d != 8'h1C) void'(ks16_next());
      end else begin
        b.e[7:0] = d ^ ks16_next();
      end
    end
    plan_q.push_back(b);
  endtask

  // Gen3+ block (or its first nbeats beats), expected from the 23-bit model.
  task automatic plan_block(input int bpb, input logic [1:0] hdr, input blk_t blk,
                            input int nbeats, input logic dis);
    beat_t      b;
    int         kind;
    int         idx;
    logic [7:0] ks;
    kind = 0;
    if (hdr == 2'b01) kind = (blk[0] == 8'hAA) ? 2 : ((blk[0] == 8'h00) ? 3 : 1);
    for (int bt = 0; bt < nbeats; bt++) begin
      b          = '0;
      b.v        = 1'b1;
      b.st       = (bt == 0);
      b.sh       = hdr;
      b.dis      = dis;
      b.e[38]    = 1'b1;
      b.e[37:36] = (bt == 0) ? hdr : 2'b00;
      for (int j = 0; j < bpb; j++) begin
        idx           = bt * bpb + j;
        b.d[8*j +: 8] = blk[idx];
        case (kind)
          0: begin
            ks = ks23_next();
            b.e[8*j +: 8] = dis ? blk[idx] : (blk[idx] ^ ks);
          end
          1: begin
            ks = ks23_next();
            b.e[8*j +: 8] = (idx == 0 || dis) ? blk[idx] : (blk[idx] ^ ks);
          end
          2: b.e[8*j +: 8] = blk[idx];
          default: begin
            b.e[8*j +: 8] = blk[idx];
            if (idx == 15) m23 = SEED;
          end
        endcase
      end
      plan_q.push_back(b);
    end
  endtask

  task automatic plan_raw(input logic [31:0] d);
    beat_t b;
    b   = '0;
    b.v = 1'b1;
    b.d = d;
    b.e = {1'b1, 2'b00, 4'h0, d};
    plan_q.push_back(b);
  endtask

  function automatic blk_t rand_blk();
    blk_t r;
    for (int i = 0; i < 16; i++) r[i] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_next();
    beat_t b;
    b = plan_q.pop_front();
    @(negedge pclk);
    link_data = b.d;
    link_k    = b.k;
    link_sh   = b.sh;
    link_st   = b.st;
    link_v    = b.v;
`ifdef PIPE_SCRAMBLE_BYPASS_EN
    scr_dis   = b.dis;
`endif
    exp_q.push_back(b.e);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [38:0] got;
    reset     = 1'b1;
    gen       = 3'd1;
    link_v    = 1'b1;
    link_data = 32'h1234_56BC;
    link_k    = 4'h1;
    link_sh   = 2'b10;
    link_st   = 1'b1;
    repeat (2) begin
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      n_vec++;
      if (got !== 39'h0) begin
        n_mis++;
        $display("FAIL reset_hold: got %h expected %h", got, 39'h0);
      end
    end
    @(negedge pclk);
    reset     = 1'b0;
    link_v    = 1'b0;
    link_data = '0;
    link_k    = '0;
    link_sh   = '0;
    link_st   = 1'b0;
    @(posedge pclk); #1;
    got = {out_v, out_sh, out_k, out_data};
    n_vec++;
    if (got !== 39'h0) begin
      n_mis++;
      $display("FAIL reset_release_idle: got %h expected %h", got, 39'h0);
    end
    m16 = 16'hFFFF;
    m23 = SEED;
  endtask

  task automatic test_gen1_com();
    logic [38:0] got, exp;
    plan_fix(8'hBC, 1'b1, 8'hBC);
    plan_fix(8'h00, 1'b0, 8'hFF);
    plan_fix(8'h00, 1'b0, 8'h17);
    plan_fix(8'h00, 1'b0, 8'hC0);
    plan_fix(8'h00, 1'b0, 8'h14);
    while (plan_q.size() > 0) begin
      drive_next();
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL gen1_com: got %h expected %h (v,sh,k,data)", got, exp);
      end
    end
  endtask

  task automatic test_gen1_skp();
    logic [38:0] got, exp;
    plan_fix(8'hBC, 1'b1, 8'hBC);
    plan_fix(8'h00, 1'b0, 8'hFF);
    plan_fix(8'h1C, 1'b1, 8'h1C);
    plan_fix(8'h00, 1'b0, 8'h17);
    while (plan_q.size() > 0) begin
      drive_next();
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL gen1_skp: got %h expected %h (v,sh,k,data)", got, exp);
      end
    end
  endtask

  task automatic test_gen12_random();
    logic [38:0] got, exp;
    logic [7:0]  ksyms[5];
    logic [7:0]  d;
    logic        k, v;
    ksyms[0] = 8'hBC; ksyms[1] = 8'h1C; ksyms[2] = 8'hF7;
    ksyms[3] = 8'hFE; ksyms[4] = 8'h7C;
    plan_g12(8'hBC, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      v = ($urandom_range(0, 7) != 0);
      k = ($urandom_range(0, 4) == 0);
      d = k ? ksyms[$urandom_range(0, 4)] : 8'($urandom_range(0, 255));
      plan_g12(d, k, v);
    end
    while (plan_q.size() > 0) begin
      drive_next();
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL gen1_random: got %h expected %h (v,sh,k,data)", got, exp);
      end
    end
    // Switching to Gen2 restarts the 16-bit scrambler without a COM.
    gen = 3'd2;
    plan_idle();
    m16 = 16'hFFFF;
    for (int i = 0; i < 12; i++) plan_g12(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    while (plan_q.size() > 0) begin
      drive_next();
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL gen2_switch: got %h expected %h (v,sh,k,data)", got, exp);
      end
    end
  endtask

  task automatic test_gen3_data();
    logic [38:0] got, exp;
    blk_t        zero;
    for (int i = 0; i < 16; i++) zero[i] = 8'h00;
    gen = 3'd3;
    plan_idle();
    m23 = SEED;
    plan_block(2, 2'b10, zero, 8, 1'b0);
    plan_block(2, 2'b10, rand_blk(), 8, 1'b0);
    while (plan_q.size() > 0) begin
      drive_next();
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL gen3_data: got %h expected %h (v,sh,k,data)", got, exp);
      end
    end
  endtask

  task automatic test_gen4_eieos();
    logic [38:0] got, exp;
    blk_t        eie;
    for (int i = 0; i < 16; i++) eie[i] = (i % 2 == 0) ? 8'h00 : 8'hFF;
    gen = 3'd4;
    plan_idle();
    m23 = SEED;
    plan_block(4, 2'b10, rand_blk(), 4, 1'b0);
    plan_block(4, 2'b01, eie, 4, 1'b0);
    plan_block(4, 2'b10, rand_blk(), 4, 1'b0);
    while (plan_q.size() > 0) begin
      drive_next();
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL gen4_eieos: got %h expected %h (v,sh,k,data)", got, exp);
      end
    end
  endtask

  task automatic test_gen4_os();
    logic [38:0] got, exp;
    blk_t        skp, ts;
    for (int i = 0; i < 16; i++) skp[i] = 8'hAA;
    ts    = rand_blk();
    ts[0] = 8'h1E;
    plan_block(4, 2'b10, rand_blk(), 4, 1'b0);
    plan_block(4, 2'b01, skp, 4, 1'b0);
    plan_block(4, 2'b10, rand_blk(), 4, 1'b0);
    plan_block(4, 2'b01, ts, 4, 1'b0);
    plan_block(4, 2'b10, rand_blk(), 4, 1'b0);
    // Beat without a block start while no block is open: passes in the clear.
    plan_raw($urandom());
    plan_block(4, 2'b10, rand_blk(), 4, 1'b0);
    while (plan_q.size() > 0) begin
      drive_next();
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL gen4_os_framing: got %h expected %h (v,sh,k,data)", got, exp);
      end
    end
  endtask

`ifdef PIPE_SCRAMBLE_BYPASS_EN
  task automatic test_bypass();
    logic [38:0] got, exp;
    plan_block(4, 2'b10, rand_blk(), 4, 1'b1);
    plan_block(4, 2'b10, rand_blk(), 4, 1'b0);
    while (plan_q.size() > 0) begin
      drive_next();
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL bypass: got %h expected %h (v,sh,k,data)", got, exp);
      end
    end
    scr_dis = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_block();
    logic [38:0] got, exp;
    gen = 3'd3;
    plan_idle();
    m23 = SEED;
    plan_block(2, 2'b10, rand_blk(), 2, 1'b0);
    while (plan_q.size() > 0) begin
      drive_next();
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL mid_reset_pre: got %h expected %h (v,sh,k,data)", got, exp);
      end
    end
    @(negedge pclk);
    reset     = 1'b1;
    link_v    = 1'b1;
    link_st   = 1'b0;
    link_data = $urandom();
    #1;
    got = {out_v, out_sh, out_k, out_data};
    n_vec++;
    if (got !== 39'h0) begin
      n_mis++;
      $display("FAIL mid_reset_async: got %h expected %h", got, 39'h0);
    end
    @(posedge pclk); #1;
    got = {out_v, out_sh, out_k, out_data};
    n_vec++;
    if (got !== 39'h0) begin
      n_mis++;
      $display("FAIL mid_reset_hold: got %h expected %h", got, 39'h0);
    end
    @(negedge pclk);
    reset  = 1'b0;
    link_v = 1'b0;
    m23    = SEED;
    plan_block(2, 2'b10, rand_blk(), 8, 1'b0);
    while (plan_q.size() > 0) begin
      drive_next();
      @(posedge pclk); #1;
      got = {out_v, out_sh, out_k, out_data};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_mis++;
        $display("FAIL mid_reset_new_block: got %h expected %h (v,sh,k,data)", got, exp);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_vec     = 0;
    n_mis     = 0;
    reset     = 1'b1;
    gen       = 3'd0;
    link_data = '0;
    link_k    = '0;
    link_sh   = '0;
    link_st   = 1'b0;
    link_v    = 1'b0;
`ifdef PIPE_SCRAMBLE_BYPASS_EN
    scr_dis   = 1'b0;
`endif
    test_reset();
    test_gen1_com();
    test_gen1_skp();
    test_gen12_random();
    test_gen3_data();
    test_gen4_eieos();
    test_gen4_os();
`ifdef PIPE_SCRAMBLE_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid_block();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
